// File: rtl/ps2_ascii_decoder.sv
// ps2_ascii_decoder: PS/2 set-2 scan codes to ASCII with make/break/extended
// prefix tracking, Shift and Caps Lock state, and a one-cycle valid strobe.
module ps2_ascii_decoder #(
  parameter logic [7:0] ENTER_CODE = 8'h0A,
  parameter logic [7:0] BS_CODE    = 8'h08
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [7:0] key_in,
  output logic       p_valid,
  output logic       shift_on,
  output logic       caps_on,
  output logic [7:0] key_count
);
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
  state_t     r_state, w_next;
  logic       r_lshift, r_rshift, r_caps, r_caps_held, r_pv;
  logic [7:0] r_key, r_cnt;
  logic       w_hit, w_let, w_emit, w_shift;
  logic [7:0] w_lo, w_hi, w_char;
  assign w_shift   = r_lshift | r_rshift;
  assign key_in    = r_key;
  assign p_valid   = r_pv;
  assign shift_on  = w_shift;
  assign caps_on   = r_caps;
  assign key_count = r_cnt;
  // w_lo/w_hi are the unshifted/shifted glyphs; letters follow shift XOR caps
  always_comb begin
    w_hit = 1'b1;
    w_let = 1'b0;
    w_lo  = 8'h00;
    case (scan_code)
      8'h1C: begin w_let = 1'b1; w_lo = "a"; end
      8'h32: begin w_let = 1'b1; w_lo = "b"; end
      8'h21: begin w_let = 1'b1; w_lo = "c"; end
      8'h23: begin w_let = 1'b1; w_lo = "d"; end
      8'h24: begin w_let = 1'b1; w_lo = "e"; end
      8'h2B: begin w_let = 1'b1; w_lo = "f"; end
      8'h34: begin w_let = 1'b1; w_lo = "g"; end
      8'h33: begin w_let = 1'b1; w_lo = "h"; end
      8'h43: begin w_let = 1'b1; w_lo = "i"; end
      8'h3B: begin w_let = 1'b1; w_lo = "j"; end
      8'h42: begin w_let = 1'b1; w_lo = "k"; end
      8'h4B: begin w_let = 1'b1; w_lo = "l"; end
      8'h3A: begin w_let = 1'b1; w_lo = "m"; end
      8'h31: begin w_let = 1'b1; w_lo = "n"; end
      8'h44: begin w_let = 1'b1; w_lo = "o"; end
      8'h4D: begin w_let = 1'b1; w_lo = "p"; end
      8'h15: begin w_let = 1'b1; w_lo = "q"; end
      8'h2D: begin w_let = 1'b1; w_lo = "r"; end
      8'h1B: begin w_let = 1'b1; w_lo = "s"; end
      8'h2C: begin w_let = 1'b1; w_lo = "t"; end
      8'h3C: begin w_let = 1'b1; w_lo = "u"; end
      8'h2A: begin w_let = 1'b1; w_lo = "v"; end
      8'h1D: begin w_let = 1'b1; w_lo = "w"; end
      8'h22: begin w_let = 1'b1; w_lo = "x"; end
      8'h35: begin w_let = 1'b1; w_lo = "y"; end
      8'h1A: begin w_let = 1'b1; w_lo = "z"; end
      default: w_lo = 8'h00;
    endcase
    w_hi = w_lo - 8'h20;
    if (!w_let)
      case (scan_code)
        8'h45: begin w_lo = "0"; w_hi = ")"; end
        8'h16: begin w_lo = "1"; w_hi = "!"; end
        8'h1E: begin w_lo = "2"; w_hi = "@"; end
        8'h26: begin w_lo = "3"; w_hi = "#"; end
        8'h25: begin w_lo = "4"; w_hi = "$"; end
        8'h2E: begin w_lo = "5"; w_hi = "%"; end
        8'h36: begin w_lo = "6"; w_hi = "^"; end
        8'h3D: begin w_lo = "7"; w_hi = "&"; end
        8'h3E: begin w_lo = "8"; w_hi = "*"; end
        8'h46: begin w_lo = "9"; w_hi = "("; end
        8'h41: begin w_lo = ","; w_hi = "<"; end
        8'h49: begin w_lo = "."; w_hi = ">"; end
        8'h4A: begin w_lo = "/"; w_hi = "?"; end
        8'h4E: begin w_lo = "-"; w_hi = "_"; end
        8'h55: begin w_lo = "="; w_hi = "+"; end
        8'h4C: begin w_lo = ";"; w_hi = ":"; end
        8'h52: begin w_lo = "'"; w_hi = "\""; end
        8'h29: begin w_lo = 8'h20;      w_hi = 8'h20;      end
        8'h5A: begin w_lo = ENTER_CODE; w_hi = ENTER_CODE; end
        8'h66: begin w_lo = BS_CODE;    w_hi = BS_CODE;    end
        default: begin w_hit = 1'b0; w_hi = 8'h00; end
      endcase
    w_char = (w_let ? (w_shift ^ r_caps) : w_shift) ? w_hi : w_lo;
  end
  always_comb begin
    w_next = r_state;
    w_emit = 1'b0;
    if (scan_valid)
      case (r_state)
        IDLE: begin
          w_next = scan_code == 8'hF0 ? BRK : scan_code == 8'hE0 ? EXT : IDLE;
          w_emit = w_hit;
        end
        EXT: begin
          w_next = scan_code == 8'hF0 ? EXT_BRK : IDLE;
          w_emit = scan_code == 8'h5A;
        end
        default: w_next = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_lshift    <= 1'b0;
      r_rshift    <= 1'b0;
      r_caps      <= 1'b0;
      r_caps_held <= 1'b0;
      r_pv        <= 1'b0;
      r_key       <= 8'h00;
      r_cnt       <= 8'h00;
    end else begin
      r_state <= w_next;
      r_pv    <= w_emit;
      if (w_emit) begin
        r_key <= w_char;
        r_cnt <= r_cnt + 8'd1;
      end
      if (scan_valid && r_state == IDLE) begin
        if (scan_code == 8'h12) r_lshift <= 1'b1;
        if (scan_code == 8'h59) r_rshift <= 1'b1;
        if (scan_code == 8'h58 && !r_caps_held) begin
          r_caps      <= ~r_caps;
          r_caps_held <= 1'b1;
        end
      end
      if (scan_valid && r_state == BRK) begin
        if (scan_code == 8'h12) r_lshift <= 1'b0;
        if (scan_code == 8'h59) r_rshift <= 1'b0;
        if (scan_code == 8'h58) r_caps_held <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// tb_ps2_ascii_decoder: directed and random scan-code streams checked against
// a table-driven keyboard model.
module tb_ps2_ascii_decoder;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic [7:0] key_in, key_count;
  logic       p_valid, shift_on, caps_on;
  int         n_tests = 0;
  int         n_fail = 0;

  ps2_ascii_decoder dut (
    .clk(clk), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
    .key_in(key_in), .p_valid(p_valid), .shift_on(shift_on), .caps_on(caps_on),
    .key_count(key_count)
  );

  always #5 clk = ~clk;

  logic [7:0] t_lo [256];
  logic [7:0] t_hi [256];
  bit         t_map [256];
  bit         t_let [256];
  logic [7:0] m_key;
  int         m_cnt;
  bit         m_pv, m_ls, m_rs, m_caps, m_held, m_brk, m_ext;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic build_tables();
    logic [7:0] lc [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                            8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                            8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    logic [7:0] dc [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    logic [7:0] pc [7]  = '{8'h41,8'h49,8'h4A,8'h4E,8'h55,8'h4C,8'h52};
    string dsh = ")!@#$%^&*(";
    string plo = ",./-=;'";
    string phi = "<>?_+:\"";
    for (int i = 0; i < 256; i++) begin t_map[i] = 0; t_let[i] = 0; end
    for (int i = 0; i < 26; i++) begin
      t_map[lc[i]] = 1; t_let[lc[i]] = 1;
      t_lo[lc[i]] = 8'h61 + 8'(i); t_hi[lc[i]] = 8'h41 + 8'(i);
    end
    for (int i = 0; i < 10; i++) begin
      t_map[dc[i]] = 1; t_lo[dc[i]] = 8'h30 + 8'(i); t_hi[dc[i]] = dsh[i];
    end
    for (int i = 0; i < 7; i++) begin
      t_map[pc[i]] = 1; t_lo[pc[i]] = plo[i]; t_hi[pc[i]] = phi[i];
    end
    t_map[8'h29] = 1; t_lo[8'h29] = 8'h20; t_hi[8'h29] = 8'h20;
    t_map[8'h5A] = 1; t_lo[8'h5A] = 8'h0A; t_hi[8'h5A] = 8'h0A;
    t_map[8'h66] = 1; t_lo[8'h66] = 8'h08; t_hi[8'h66] = 8'h08;
  endtask

  task automatic model_reset();
    m_key = 0; m_cnt = 0; m_pv = 0;
    m_ls = 0; m_rs = 0; m_caps = 0; m_held = 0; m_brk = 0; m_ext = 0;
  endtask

  task automatic model_emit(input logic [7:0] c);
    m_key = c; m_pv = 1; m_cnt = (m_cnt + 1) % 256;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit up;
    m_pv = 0;
    if (m_brk) begin
      if (!m_ext) begin
        if (b == 8'h12) m_ls = 0;
        if (b == 8'h59) m_rs = 0;
        if (b == 8'h58) m_held = 0;
      end
      m_brk = 0; m_ext = 0;
    end else if (b == 8'hF0) m_brk = 1;
    else if (m_ext) begin
      if (b == 8'h5A) model_emit(8'h0A);
      m_ext = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'h12) m_ls = 1;
    else if (b == 8'h59) m_rs = 1;
    else if (b == 8'h58) begin
      if (!m_held) begin m_caps = !m_caps; m_held = 1; end
    end else if (t_map[b]) begin
      up = t_let[b] ? ((m_ls | m_rs) ^ m_caps) : (m_ls | m_rs);
      model_emit(up ? t_hi[b] : t_lo[b]);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".p_valid"}, {7'd0, p_valid}, {7'd0, m_pv});
    check({tag, ".key_in"}, key_in, m_key);
    check({tag, ".key_count"}, key_count, 8'(m_cnt));
    check({tag, ".shift_on"}, {7'd0, shift_on}, {7'd0, m_ls | m_rs});
    check({tag, ".caps_on"}, {7'd0, caps_on}, {7'd0, m_caps});
  endtask

  task automatic step(input bit v, input logic [7:0] b, input string tag);
    scan_valid = v;
    scan_code = b;
    @(posedge clk);
    if (v) model_byte(b); else m_pv = 0;
    #1;
    compare_all(tag);
  endtask

  task automatic send(input logic [7:0] seq [$], input string tag);
    foreach (seq[i]) step(1'b1, seq[i], tag);
    step(1'b0, 8'h00, tag);
  endtask

  logic [7:0] pool [16] = '{8'h12,8'h59,8'h58,8'hF0,8'hE0,8'h5A,8'h66,8'h29,
                           8'h1C,8'h16,8'h45,8'h52,8'h4E,8'h07,8'h1A,8'h41};

  initial begin
    build_tables();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 8'h1C, "first_a");
    check("first_a.key", key_in, 8'h61);
    step(1'b0, 8'h00, "first_a_done");
    send('{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C}, "shift_seq");
    send('{8'h58, 8'h58, 8'hF0, 8'h58, 8'h16, 8'h1C}, "caps_seq");
    check("caps_hold", {7'd0, caps_on}, 8'd1);
    send('{8'h58, 8'hF0, 8'h58}, "caps_off");
    send('{8'hE0, 8'h5A, 8'hE0, 8'hF0, 8'h5A, 8'hE0, 8'h75, 8'h5A, 8'h66}, "ext_seq");
    send('{8'h59, 8'h16, 8'h52, 8'hE0, 8'hF0, 8'h59, 8'h4E, 8'hF0, 8'h59, 8'h4E}, "rshift_seq");
    while (m_cnt != 0) step(1'b1, 8'h29, "align");
    for (int i = 0; i < 256; i++) step(1'b1, 8'h1C, "burst");
    check("burst_wrap", key_count, 8'h00);
    step(1'b1, 8'h07, "unmapped");
    check("unmapped_pv", {7'd0, p_valid}, 8'd0);
    step(1'b1, 8'hE0, "pre_reset");
    scan_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_all("async_reset");
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 8'h5A, "post_reset");
    check("post_reset_key", key_in, 8'h0A);
    for (int i = 0; i < 3000; i++) begin
      bit v = $urandom_range(3) != 0;
      logic [7:0] b = $urandom_range(3) == 0 ? 8'($urandom) : pool[$urandom_range(15)];
      step(v, b, "rand");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_ascii_decoder.md
# ps2_ascii_decoder

Converts the raw PS/2 set-2 scan-code byte stream from the keyboard receiver into ASCII characters with a one-cycle valid strobe. Sits directly upstream of the text-mode video memory and drives its `key_in`/`p_valid` inputs. Tracks make/break/extended prefixes, Shift and Caps Lock state, and emits only printable characters plus Enter (0x0A) and Backspace (0x08).

## Interface
- `ENTER_CODE`, default 8'h0A: ASCII emitted for Enter and keypad Enter.
- `BS_CODE`, default 8'h08: ASCII emitted for Backspace.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `scan_code`  in  8  scan-code byte from the receiver; sampled only when `scan_valid`=1.
- `scan_valid`  in  1  one-cycle strobe per received byte; may be high on consecutive cycles.
- `key_in`  out  8  ASCII of the last emitted character; held between emits.
- `p_valid`  out  1  one-cycle pulse per emitted character.
- `shift_on`  out  1  left OR right Shift currently held.
- `caps_on`  out  1  Caps Lock toggle state.
- `key_count`  out  8  number of emitted characters, modulo 256.

## Operation
- FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0). Transitions occur only on cycles with `scan_valid`=1.
- IDLE: F0->BRK; E0->EXT. 12 sets lshift, 59 sets rshift, no emit. 58: if caps_held=0, toggle caps_on and set caps_held; no emit. Any other code: look up; if mapped, emit; stay IDLE.
- BRK: any byte->IDLE. 12 clears lshift, 59 clears rshift, 58 clears caps_held. Never emits.
- EXT: F0->EXT_BRK. 5A emits ENTER_CODE, then IDLE. Any other byte->IDLE with no emit.
- EXT_BRK: any byte->IDLE; no emit.
- Typematic repeats of a mapped make code emit each time. Repeats of 58 do not re-toggle Caps Lock.
- Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z. Output is uppercase iff shift_on XOR caps_on.
- Digits, unshifted / shifted: 45 '0'/')', 16 '1'/'!', 1E '2'/'@', 26 '3'/'#', 25 '4'/'$', 2E '5'/'%', 36 '6'/'^', 3D '7'/'&', 3E '8'/'*', 46 '9'/'('. Caps Lock has no effect.
- Punctuation, unshifted / shifted: 41 ','/'<', 49 '.'/'>', 4A '/'/'?', 4E '-'/'_', 55 '='/'+', 4C ';'/':', 52 '\''/'"'.
- Shift-independent: 29 -> 0x20, 5A -> ENTER_CODE, 66 -> BS_CODE.
- All other codes, including unknown or unmapped ones, produce no emit and cause no error.
- Shift level used for an emit is the state before the current byte is processed.

## Timing
- Registered outputs. If `scan_valid` is sampled at edge N and the byte emits, then from edge N+1: `key_in` holds the new value, `p_valid`=1 for exactly one cycle, and `key_count` is incremented.
- `shift_on` and `caps_on` update at the same edge the controlling byte is sampled, and are visible after that edge.
- Back-to-back bytes, one per cycle, are fully supported with no stall and no dropped bytes. Consecutive emitting bytes produce consecutive `p_valid` cycles.
- `key_count` wraps from 255 to 0.
- Reset values: state=IDLE; `key_in`=0; `p_valid`=0; `shift_on`=0; `caps_on`=0; `key_count`=0; lshift, rshift, caps_held=0.
- Reset asserted mid-sequence, for example between E0 and 5A, discards the partial prefix. The next byte after release is decoded from IDLE.

## Test plan
- Reset release, then byte 1C -> one `p_valid` pulse one cycle later, `key_in`=0x61, `key_count`=1.
- Sequence 12, 1C, F0 1C, F0 12, 1C -> emits 0x41 then 0x61. `shift_on` rises after 12 and falls after F0 12.
- Sequence 58, 58, F0 58, 16, 1C -> `caps_on`=1 after the first 58 and is not re-toggled by the repeat. Emits 0x31 then 0x41.
- Sequence E0 5A, E0 F0 5A, E0 75, 5A, 66 -> emits exactly 0x0A, 0x0A, 0x08. E0 75 and all break bytes emit nothing.
- 256 consecutive 1C bytes on back-to-back cycles -> 256 contiguous `p_valid` cycles and `key_count` returns to 0. Then byte 0x07 (unmapped) -> no pulse and `key_in` unchanged.
- Reset pulsed low after E0 -> all outputs 0 immediately. Then 5A -> emits 0x0A via the IDLE path and `shift_on`=0.
